// File: rtl/seven_seg_if.sv
// seven_seg_if
//   Bundles the digit data coming from the counter stage with the
//   multiplexed display drive going out to the LED module.
//
//   bcd_in      [15:0] digit3..digit0, [3:0] is the rightmost digit
//   dp_in       [3:0]  decimal point request, bit i belongs to digit i
//   lz_blank           1 = suppress leading zeros
//   display     [6:0]  segments a..g (bit0=a), active-low
//   dp                 decimal point, active-low
//   digit_sel   [3:0]  common-anode enables, active-low
//   frame_start        one-cycle pulse when a new frame begins
//
//   master : the side that supplies digits and receives the drive (counter / bench)
//   slave  : the scanner itself
interface seven_seg_if;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [6:0]  display;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_start;

    modport master (
        output bcd_in, dp_in, lz_blank,
        input  display, dp, digit_sel, frame_start
    );

    modport slave (
        input  bcd_in, dp_in, lz_blank,
        output display, dp, digit_sel, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes four BCD digits onto one shared active-low 7-segment
//   bus with four active-low common-anode selects. Each digit slot lasts
//   SLOT_CYCLES clocks and begins with BLANK_CYCLES clocks of all-off to
//   avoid ghosting. The inputs are snapshotted at the start of each frame
//   so a value never tears across digits. Optional leading-zero blanking.
//
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   seven_seg_if.slave (digit inputs in, segment/anode drive out)
module seven_seg_scanner #(
    parameter int SLOT_CYCLES  = 50000,  // clocks per digit slot, >= 2
    parameter int BLANK_CYCLES = 2000    // blank clocks at slot start, < SLOT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    seven_seg_if.slave  bus
);

    localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    // Snapshot window is at least one cycle wide even with no blanking.
    localparam logic [CNT_W-1:0] SNAP_END  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES : 1);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        case (value)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    // Current scan position and frame snapshot.
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      sh_bcd;
    logic [3:0]       sh_dp;
    logic             sh_lz;

    // Post-edge values; outputs are decoded from these so they line up
    // with the state they describe on the same edge.
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       idx_nxt;
    logic [15:0]      sh_bcd_nxt;
    logic [3:0]       sh_dp_nxt;
    logic             sh_lz_nxt;
    phase_t           phase_nxt;
    logic [3:0]       digit_val;
    logic             suppress;
    logic [6:0]       display_nxt;
    logic             dp_nxt;
    logic [3:0]       digit_sel_nxt;
    logic             frame_start_nxt;
    logic             snap;
    logic             wrap;
    logic [3:0]       is_zero;
    logic [3:0]       lead_zero;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        cnt_nxt         = cnt;
        idx_nxt         = idx;
        wrap            = (cnt == CNT_LAST);
        frame_start_nxt = 1'b0;

        if (rst) begin
            cnt_nxt = '0;
            idx_nxt = '0;
        end else begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            idx_nxt = wrap ? idx + 2'd1 : idx;
            frame_start_nxt = wrap && (idx == 2'd3);
        end

        // Snapshot while the first slot of the frame is still dark; reset
        // lands in (0,0), which is always inside the window.
        snap       = (idx_nxt == 2'd0) && (cnt_nxt < SNAP_END);
        sh_bcd_nxt = snap ? bus.bcd_in   : sh_bcd;
        sh_dp_nxt  = snap ? bus.dp_in    : sh_dp;
        sh_lz_nxt  = snap ? bus.lz_blank : sh_lz;

        for (int i = 0; i < 4; i++) begin
            is_zero[i] = (sh_bcd_nxt[4*i +: 4] == 4'd0);
        end
        // A digit is a leading zero when it and every digit left of it are 0.
        lead_zero[3] = is_zero[3];
        lead_zero[2] = is_zero[2] && lead_zero[3];
        lead_zero[1] = is_zero[1] && lead_zero[2];
        lead_zero[0] = 1'b0;

        digit_val = sh_bcd_nxt[{idx_nxt, 2'b00} +: 4];
        suppress  = sh_lz_nxt && lead_zero[idx_nxt];

        phase_nxt = (!rst && (cnt_nxt >= BLANK_END)) ? PH_SHOW : PH_BLANK;

        display_nxt   = SEG_OFF;
        dp_nxt        = 1'b1;
        digit_sel_nxt = 4'hF;
        if (phase_nxt == PH_SHOW) begin
            digit_sel_nxt = ~(4'b0001 << idx_nxt);
            display_nxt   = suppress ? SEG_OFF : seg_decode(digit_val);
            dp_nxt        = ~sh_dp_nxt[idx_nxt];
        end
    end

    // The snapshot is loaded from the inputs on reset rather than cleared,
    // so the first frame after reset already shows live data.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        cnt             <= cnt_nxt;
        idx             <= idx_nxt;
        sh_bcd          <= sh_bcd_nxt;
        sh_dp           <= sh_dp_nxt;
        sh_lz           <= sh_lz_nxt;
        bus.display     <= display_nxt;
        bus.dp          <= dp_nxt;
        bus.digit_sel   <= digit_sel_nxt;
        bus.frame_start <= frame_start_nxt;
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Directed scenarios followed by randomized digits/resets, every edge
//   checked against a frame-level model: the scan position is derived
//   from the number of edges since the last reset edge.
module tb_seven_seg_scanner;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic rst;

    seven_seg_if bus ();

    seven_seg_scanner #(
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: edges since the last reset edge (reset edge itself is 0),
    // plus the frame snapshot.
    int          n = 0;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    logic        m_lz;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    // One clock edge: drive inputs at negedge, advance the model on the
    // posedge, compare all outputs just after it.
    task automatic step(input logic r, input logic [15:0] b, input logic [3:0] d, input logic l);
        int          slot;
        int          c;
        logic        blank;
        logic        sup;
        logic [6:0]  e_disp;
        logic        e_dp;
        logic [3:0]  e_sel;
        logic        e_fs;
        @(negedge clk);
        rst          = r;
        bus.bcd_in   = b;
        bus.dp_in    = d;
        bus.lz_blank = l;
        @(posedge clk);
        if (r) n = 0;
        else   n = n + 1;
        slot = (n / SLOT) % 4;
        c    = n % SLOT;
        if (r || (slot == 0 && c < BLANK)) begin
            m_bcd = b;
            m_dp  = d;
            m_lz  = l;
        end
        blank = r || (c < BLANK);
        // Leading zero: this digit and everything above it are all zero.
        sup   = m_lz && (slot != 0) && ((m_bcd >> (4 * slot)) == 16'd0);
        e_disp = blank ? 7'h7F : (sup ? 7'h7F : seg_of(int'(m_bcd[4*slot +: 4])));
        e_dp   = blank ? 1'b1 : ~m_dp[slot];
        e_sel  = blank ? 4'hF : (4'hF ^ (4'b0001 << slot));
        e_fs   = !r && (n > 0) && (n % FRAME == 0);
        #1;
        check("display",     16'(bus.display),     16'(e_disp));
        check("dp",          16'(bus.dp),          16'(e_dp));
        check("digit_sel",   16'(bus.digit_sel),   16'(e_sel));
        check("frame_start", 16'(bus.frame_start), 16'(e_fs));
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        rst          = 1'b1;
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.lz_blank = 1'b0;

        // Reset held for several edges with arbitrary inputs.
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 4'($urandom), 1'($urandom));

        // Plain scan of 1238, through one frame wrap.
        step(1'b1, 16'h1238, 4'h0, 1'b0);
        for (int i = 1; i <= 40; i++) step(1'b0, 16'h1238, 4'h0, 1'b0);

        // Leading-zero suppression on and off.
        step(1'b1, 16'h0050, 4'h0, 1'b1);
        for (int i = 1; i <= 33; i++) step(1'b0, 16'h0050, 4'h0, 1'b1);
        step(1'b1, 16'h0050, 4'h0, 1'b0);
        for (int i = 1; i <= 33; i++) step(1'b0, 16'h0050, 4'h0, 1'b0);

        // Snapshot: input change at edge 5 waits for the next frame.
        step(1'b1, 16'h1238, 4'h0, 1'b0);
        for (int i = 1; i <= 4; i++)  step(1'b0, 16'h1238, 4'h0, 1'b0);
        for (int i = 5; i <= 40; i++) step(1'b0, 16'h9999, 4'h0, 1'b0);

        // Invalid code and decimal point on digit 0.
        step(1'b1, 16'h000C, 4'b0001, 1'b0);
        for (int i = 1; i <= 33; i++) step(1'b0, 16'h000C, 4'b0001, 1'b0);

        // Reset mid-frame at edge 20, then a full clean scan.
        step(1'b1, 16'h1238, 4'h0, 1'b0);
        for (int i = 1; i <= 19; i++) step(1'b0, 16'h1238, 4'h0, 1'b0);
        step(1'b1, 16'h1238, 4'h0, 1'b0);
        for (int i = 1; i <= 40; i++) step(1'b0, 16'h1238, 4'h0, 1'b0);

        // Randomized digits, decimal points, blanking and occasional reset.
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 99) == 0), rand_bcd(), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
